// File: rtl/onehot_grant_decoder_if.sv
// rtl/onehot_grant_decoder_if.sv - handshake and grant bus between encoder, decoder and consumer
interface onehot_grant_decoder_if #(
    parameter int IDX_W = 2
);
    localparam int OUT_W = 1 << IDX_W;

    logic [IDX_W-1:0] in_code;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             ack;
    logic             busy;

    // Upstream encoder and downstream consumer side
    modport master (
        output in_code, in_valid, ack,
        input  in_ready, out, out_valid, busy
    );

    // Decoder side
    modport slave (
        input  in_code, in_valid, ack,
        output in_ready, out, out_valid, busy
    );
endinterface

// File: rtl/onehot_grant_decoder.sv
// rtl/onehot_grant_decoder.sv - registered 2-to-4 grant decoder, break-before-make, optional DEC_AUTO_RELEASE_EN
module onehot_grant_decoder #(
    parameter int IDX_W       = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    onehot_grant_decoder_if.slave  bus
);
    localparam int OUT_W = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [IDX_W-1:0] pend_code_q, pend_code_d;
    logic             pend_valid_q, pend_valid_d;
    logic             transfer;
    logic             release_grant;

`ifdef DEC_AUTO_RELEASE_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

    function automatic logic [OUT_W-1:0] onehot(input logic [IDX_W-1:0] code);
        logic [OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    // State register: async reset drops the grant and discards any pending code at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            out_q        <= '0;
            pend_code_q  <= '0;
            pend_valid_q <= 1'b0;
`ifdef DEC_AUTO_RELEASE_EN
            hold_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            pend_code_q  <= pend_code_d;
            pend_valid_q <= pend_valid_d;
`ifdef DEC_AUTO_RELEASE_EN
            hold_cnt_q   <= hold_cnt_d;
`endif
        end
    end

    // Next-state: grant/gap sequencing, pending buffer fill/drain, hold counting
    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        pend_code_d  = pend_code_q;
        pend_valid_d = pend_valid_q;
        transfer     = bus.in_valid && !pend_valid_q;
`ifdef DEC_AUTO_RELEASE_EN
        hold_cnt_d    = hold_cnt_q;
        release_grant = bus.ack || (hold_cnt_q == HOLD_LAST);
`else
        release_grant = bus.ack;
`endif
        case (state_q)
            IDLE: begin
                // Idle transfers bypass the pending buffer
                if (transfer) begin
                    state_d = GRANT;
                    out_d   = onehot(bus.in_code);
`ifdef DEC_AUTO_RELEASE_EN
                    hold_cnt_d = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (transfer) begin
                    pend_code_d  = bus.in_code;
                    pend_valid_d = 1'b1;
                end
`ifdef DEC_AUTO_RELEASE_EN
                if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
`endif
                if (release_grant) begin
                    state_d = GAP;
                    out_d   = '0;
                end
            end
            GAP: begin
                // Pending code wins; in_ready is low then, so no transfer can collide
                if (pend_valid_q) begin
                    state_d      = GRANT;
                    out_d        = onehot(pend_code_q);
                    pend_valid_d = 1'b0;
`ifdef DEC_AUTO_RELEASE_EN
                    hold_cnt_d = 8'd0;
`endif
                end else if (transfer) begin
                    state_d = GRANT;
                    out_d   = onehot(bus.in_code);
`ifdef DEC_AUTO_RELEASE_EN
                    hold_cnt_d = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase
    end

    // Outputs: all derived from registers, in_ready never looks at in_valid
    always_comb begin
        bus.out       = out_q;
        bus.out_valid = (state_q == GRANT);
        bus.in_ready  = !pend_valid_q;
        bus.busy      = (state_q != IDLE) || pend_valid_q;
    end
endmodule

// File: tb/tb_onehot_grant_decoder.sv
// tb/tb_onehot_grant_decoder.sv - randomized and directed bench with queue-based reference model
module tb_onehot_grant_decoder;
    localparam int IDX_W = 2;
    localparam int OUT_W = 4;
    localparam int HOLD  = 4;
`ifdef DEC_AUTO_RELEASE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    onehot_grant_decoder_if #(.IDX_W(IDX_W)) ifc ();

    onehot_grant_decoder #(.IDX_W(IDX_W), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: current grant (-1 none), gap flag, queue of waiting codes
    int m_grant;
    bit m_gap;
    int m_fifo[$];
    int m_age;
    // Scoreboard of codes accepted by the DUT handshake, popped as grants appear
    int sb[$];
    bit prev_ov;

    function automatic void model_reset();
        m_grant = -1;
        m_gap   = 1'b0;
        m_fifo.delete();
        m_age   = 0;
        sb.delete();
        prev_ov = 1'b0;
    endfunction

    function automatic void model_step();
        bit acc;
        bit rel;
        acc = ifc.in_valid && (m_fifo.size() == 0);
        if (m_grant >= 0) begin
            rel = ifc.ack || (AUTO && (m_age == HOLD - 1));
            if (acc) m_fifo.push_back(int'(ifc.in_code));
            if (rel) begin
                m_grant = -1;
                m_gap   = 1'b1;
            end else if (m_age < 255) begin
                m_age++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
            if (m_fifo.size() != 0) begin
                m_grant = m_fifo.pop_front();
                m_age   = 0;
            end else if (acc) begin
                m_grant = int'(ifc.in_code);
                m_age   = 0;
            end
        end else if (acc) begin
            m_grant = int'(ifc.in_code);
            m_age   = 0;
        end
    endfunction

    function automatic int oh_idx(input logic [OUT_W-1:0] v);
        for (int i = 0; i < OUT_W; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic compare(input string tag);
        logic [31:0] exp_out;
        exp_out = (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0;
        check({tag, ".out"}, 32'(ifc.out), exp_out);
        check({tag, ".out_valid"}, 32'(ifc.out_valid), 32'(m_grant >= 0));
        check({tag, ".in_ready"}, 32'(ifc.in_ready), 32'(m_fifo.size() == 0));
        check({tag, ".busy"}, 32'(ifc.busy), 32'((m_grant >= 0) || m_gap || (m_fifo.size() != 0)));
    endtask

    task automatic tick(input string tag);
        int c;
        if (ifc.in_valid && ifc.in_ready) sb.push_back(int'(ifc.in_code));
        model_step();
        @(posedge clk);
        #1;
        compare(tag);
        if (ifc.out_valid && !prev_ov) begin
            check({tag, ".order_avail"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                c = sb.pop_front();
                check({tag, ".order_code"}, 32'(oh_idx(ifc.out)), 32'(c));
            end
        end
        prev_ov = ifc.out_valid;
    endtask

    task automatic drive(input logic v, input logic [IDX_W-1:0] c, input logic a);
        ifc.in_valid = v;
        ifc.in_code  = c;
        ifc.ack      = a;
    endtask

    int cnt;

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd0, 1'b0);
        model_reset();
        #12;
        compare("reset");
        check("reset.in_ready", 32'(ifc.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Decode map
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 2'(c), 1'b0);
            tick("dec");
            check("dec.onehot", 32'(ifc.out), 32'd1 << c);
            drive(1'b0, 2'd0, 1'b1);
            tick("dec_ack");
            drive(1'b0, 2'd0, 1'b0);
            tick("dec_idle");
        end

        // Ack timing: transfer at cycle 0, ack at cycle 3
        drive(1'b1, 2'd2, 1'b0);
        tick("ackt1");
        drive(1'b0, 2'd0, 1'b0);
        tick("ackt2");
        tick("ackt3");
        check("ackt.c3_out", 32'(ifc.out), 32'h4);
        drive(1'b0, 2'd0, 1'b1);
        tick("ackt4");
        check("ackt.gap_out", 32'(ifc.out), 32'h0);
        drive(1'b0, 2'd0, 1'b0);
        tick("ackt5");
        check("ackt.busy", 32'(ifc.busy), 32'd0);

        // Back-to-back and backpressure: 00, 11 pending, 01 stalled
        drive(1'b1, 2'd0, 1'b0);
        tick("b2b_g0");
        drive(1'b1, 2'd3, 1'b0);
        tick("b2b_pend");
        check("b2b.ready_low", 32'(ifc.in_ready), 32'd0);
        drive(1'b1, 2'd1, 1'b0);
        tick("b2b_stall");
        check("b2b.stall_ready", 32'(ifc.in_ready), 32'd0);
        check("b2b.stall_out", 32'(ifc.out), 32'h1);
        drive(1'b1, 2'd1, 1'b1);
        tick("b2b_gap");
        check("b2b.gap_out", 32'(ifc.out), 32'h0);
        drive(1'b1, 2'd1, 1'b0);
        tick("b2b_g3");
        check("b2b.g3_out", 32'(ifc.out), 32'h8);
        check("b2b.ready_back", 32'(ifc.in_ready), 32'd1);
        tick("b2b_take1");
        drive(1'b0, 2'd0, 1'b1);
        tick("b2b_gap2");
        drive(1'b0, 2'd0, 1'b0);
        tick("b2b_g1");
        check("b2b.g1_out", 32'(ifc.out), 32'h2);
        drive(1'b0, 2'd0, 1'b1);
        tick("b2b_gap3");
        drive(1'b0, 2'd0, 1'b0);
        tick("b2b_idle");

        // Auto-release window with ack never asserted
        drive(1'b1, 2'd1, 1'b0);
        tick("auto0");
        drive(1'b0, 2'd0, 1'b0);
        cnt = (ifc.out == 4'h2) ? 1 : 0;
        for (int i = 1; i < 20; i++) begin
            tick("auto");
            if (ifc.out == 4'h2) cnt++;
        end
        check("auto.grant_cycles", 32'(cnt), AUTO ? 32'd4 : 32'd20);
        drive(1'b0, 2'd0, 1'b1);
        tick("auto_ack");
        drive(1'b0, 2'd0, 1'b0);
        tick("auto_gap");
        tick("auto_idle");

        // Reset mid-GRANT with a pending code
        drive(1'b1, 2'd2, 1'b0);
        tick("rst_g");
        drive(1'b1, 2'd1, 1'b0);
        tick("rst_p");
        drive(1'b0, 2'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst.out", 32'(ifc.out), 32'h0);
        check("rst.out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst.in_ready", 32'(ifc.in_ready), 32'd1);
        check("rst.busy", 32'(ifc.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2'd3, 1'b0);
        tick("rst_after");
        check("rst.after_out", 32'(ifc.out), 32'h8);
        drive(1'b0, 2'd0, 1'b1);
        tick("rst_ack");
        drive(1'b0, 2'd0, 1'b0);
        tick("rst_idle");

        // Randomized traffic; upstream holds a stalled offer stable
        for (int i = 0; i < 3000; i++) begin
            if (!(ifc.in_valid && !ifc.in_ready)) begin
                ifc.in_valid = ($urandom_range(0, 99) < 50);
                ifc.in_code  = 2'($urandom_range(0, 3));
            end
            ifc.ack = ($urandom_range(0, 99) < 30);
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
